// File: rtl/selecter.sv
// Registered 3-way data selector: SW picks A, B or C onto O, and EN flags whether SW named a real source.
// IN_STAGE=1 adds an input register on A/B/C/SW, so data and select move through the pipeline together.
module selecter #(
    parameter int WIDTH    = 3,
    parameter int IN_STAGE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [1:0]       SW,
    output logic [WIDTH-1:0] O,
    output logic             EN
);

    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] c_s;
    logic [1:0]       sw_s;

    generate
        if (IN_STAGE != 0) begin : g_in_stage
            // A cleared stage decodes as SW=00 with A=0, so O=0/EN=1 on the first edge after reset release.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    a_s  <= '0;
                    b_s  <= '0;
                    c_s  <= '0;
                    sw_s <= 2'b00;
                end else begin
                    a_s  <= A;
                    b_s  <= B;
                    c_s  <= C;
                    sw_s <= SW;
                end
            end
        end else begin : g_direct
            assign a_s  = A;
            assign b_s  = B;
            assign c_s  = C;
            assign sw_s = SW;
        end
    endgenerate

    logic [WIDTH-1:0] o_next;
    logic             en_next;

    always_comb begin
        o_next  = '0;
        en_next = 1'b1;
        case (sw_s)
            2'b00:   o_next = a_s;
            2'b01:   o_next = b_s;
            2'b10:   o_next = c_s;
            default: begin
                o_next  = '0;
                en_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            O  <= '0;
            EN <= 1'b0;
        end else begin
            O  <= o_next;
            EN <= en_next;
        end
    end

endmodule

// File: tb/tb_selecter.sv
// Self-checking bench for selecter: one instance per IN_STAGE setting, compared every edge against a
// history-based reference model, with directed cases followed by randomized traffic and resets.
module tb_selecter;

    localparam int WIDTH = 3;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic [1:0]       sw;
    } sample_t;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [WIDTH-1:0] A   = '0;
    logic [WIDTH-1:0] B   = '0;
    logic [WIDTH-1:0] C   = '0;
    logic [1:0]       SW  = 2'b00;
    logic [WIDTH-1:0] o_l1;
    logic             en_l1;
    logic [WIDTH-1:0] o_l2;
    logic             en_l2;

    int checks   = 0;
    int failures = 0;

    // Per-edge samples as the DUT's input side would see them; zeros stand in for edges under reset.
    sample_t hist[$];

    always #5 CLK = ~CLK;

    selecter #(.WIDTH(WIDTH), .IN_STAGE(0)) dut_l1 (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .C(C), .SW(SW), .O(o_l1), .EN(en_l1)
    );

    selecter #(.WIDTH(WIDTH), .IN_STAGE(1)) dut_l2 (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .C(C), .SW(SW), .O(o_l2), .EN(en_l2)
    );

    function automatic logic [WIDTH:0] expectSel(input sample_t s);
        case (s.sw)
            2'b00:   return {1'b1, s.a};
            2'b01:   return {1'b1, s.b};
            2'b10:   return {1'b1, s.c};
            default: return '0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [WIDTH:0] observed, input logic [WIDTH:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed EN/O=%b expected EN/O=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare both instances against the model.
    task automatic applyStimulus(input logic r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] c, input logic [1:0] sw, input string tag);
        sample_t cur;
        logic [WIDTH:0] exp_l1;
        logic [WIDTH:0] exp_l2;
        RST = r;
        A   = a;
        B   = b;
        C   = c;
        SW  = sw;
        @(posedge CLK);
        cur = r ? sample_t'('0) : sample_t'{a, b, c, sw};
        hist.push_back(cur);
        exp_l1 = r ? '0 : expectSel(hist[$]);
        exp_l2 = r ? '0 : expectSel(hist[$-1]);
        #1;
        checkOutput({tag, "/lat1"}, {en_l1, o_l1}, exp_l1);
        checkOutput({tag, "/lat2"}, {en_l2, o_l2}, exp_l2);
        @(negedge CLK);
    endtask

    // Raise reset between edges and confirm both outputs clear without a clock edge.
    task automatic asyncReset(input string tag);
        #1;
        RST = 1'b1;
        #1;
        hist[$] = '0;
        checkOutput({tag, "/async_lat1"}, {en_l1, o_l1}, '0);
        checkOutput({tag, "/async_lat2"}, {en_l2, o_l2}, '0);
    endtask

    initial begin
        hist.push_back('0);
        A   = 3'b001;
        B   = 3'b010;
        C   = 3'b100;
        SW  = 2'b00;
        RST = 1'b1;
        #1;
        checkOutput("reset_pre_edge_lat1", {en_l1, o_l1}, '0);
        checkOutput("reset_pre_edge_lat2", {en_l2, o_l2}, '0);
        @(negedge CLK);
        applyStimulus(1'b1, 3'b001, 3'b010, 3'b100, 2'b00, "reset_held");

        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b00, "sw00_a");
        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b00, "sw00_b");
        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b01, "sw01");
        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b10, "sw10");
        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b11, "sw11");
        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b00, "back_sw00");
        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b11, "sw11_again");
        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b11, "sw11_hold");

        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b01, "holdB_010");
        applyStimulus(1'b0, 3'b110, 3'b111, 3'b011, 2'b01, "holdB_111");
        applyStimulus(1'b0, 3'b001, 3'b101, 3'b100, 2'b01, "holdB_101");
        applyStimulus(1'b0, 3'b111, 3'b101, 3'b000, 2'b01, "holdB_toggle");

        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b00, "walk_00");
        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b01, "walk_01");
        asyncReset("walk_mid");
        applyStimulus(1'b1, 3'b001, 3'b010, 3'b100, 2'b10, "walk_rst");
        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b10, "walk_10");
        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b11, "walk_11");
        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b00, "walk_00_end");
        applyStimulus(1'b0, 3'b001, 3'b010, 3'b100, 2'b01, "walk_01_end");

        for (int i = 0; i < 300; i++) begin
            logic r;
            r = ($urandom_range(0, 24) == 0);
            applyStimulus(r, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), 2'($urandom), "rand");
            if (!r && $urandom_range(0, 39) == 0) begin
                asyncReset("rand");
                applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), 2'($urandom), "rand_rst");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
